text_renderer: RTL and testbench
================================

# text_renderer

Streams a short text message onto the VGA raster by driving the glyph font lookup (letter index, glyph column, glyph row) from live pixel coordinates and registering the returned glyph bit into a per-pixel "text on" flag. It sits between the VGA timing generator and the pixel colour mux, and is the requester side of the font lookup interface. A message buffer is loaded character by character through a valid/ready write port. An optional frame-based blink gates the output.

## Interface
Parameters:
- MSG_LEN, 16: character slots in the message buffer (2..32).
- ORIGIN_X, 10'd192: left pixel column of the text box.
- ORIGIN_Y, 10'd224: top pixel row of the text box.
- SCALE_LOG2, 1: glyph magnification, 2^SCALE_LOG2 (0..2).

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- sys_rst  in  1  asynchronous, active-high reset.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current pixel row.
- pix_valid  in  1  pix_x/pix_y lie in the active area.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- wr_en  in  1  write-port valid.
- wr_char  in  5  character code: 0..25 = A..Z; 26..31 = blank.
- wr_last  in  1  marks the final character of a message.
- wr_ready  out  1  buffer accepts a write.
- blink_en  in  1  enable blinking.
- letter_i  out  5  glyph index to the font block.
- letter_x  out  4  glyph column 0..15.
- letter_y  out  4  glyph row 0..15.
- letter_o  in  1  glyph bit returned combinationally by the font block.
- text_valid  out  1  pix_valid delayed by 2 cycles.
- text_on  out  1  pixel is a lit glyph bit; aligned with text_valid.

## Operation
- Write FSM has two states, SHOW and LOAD. Reset state is SHOW with msg_len = 0.
- SHOW → LOAD: on the first accepted write (wr_en && wr_ready). That write stores its character at slot 0 and sets wr_ptr = 1.
- In LOAD, each accepted write stores wr_char at slot wr_ptr and increments wr_ptr.
- LOAD → SHOW: on an accepted write with wr_last = 1, or on the write to slot MSG_LEN-1. msg_len is set to the number of characters written.
- wr_ready = 1 in both states. The single exception is the cycle that commits LOAD → SHOW, when wr_ready = 0; that cycle is a 1-cycle gap.
- While in LOAD, text_on is forced to 0 so that half-written messages are never shown.
- Text box size:
  - width = msg_len × 16 × 2^SCALE_LOG2 pixels.
  - height = 16 × 2^SCALE_LOG2 pixels.
  - dx = pix_x − ORIGIN_X and dy = pix_y − ORIGIN_Y, both 10-bit unsigned.
  - hit = pix_valid && pix_x ≥ ORIGIN_X && pix_y ≥ ORIGIN_Y && dx < width && dy < height.
- Lookup fields:
  - character slot = dx >> (4 + SCALE_LOG2)
  - letter_x = (dx >> SCALE_LOG2)[3:0]
  - letter_y = (dy >> SCALE_LOG2)[3:0]
  - letter_i = buffer[slot]
- Blank codes (26..31) and non-hit pixels both produce text_on = 0, regardless of letter_o. For these pixels letter_i is driven as 0.
- Blink: a 6-bit frame counter increments on each frame_start and wraps 63 → 0. When blink_en = 1 and counter[5] = 1, text_on = 0, giving 32 frames on and 32 off. When blink_en = 0 the blink has no effect, but the counter keeps running.

## Timing
- Stage 1 (registered on vga_clk): letter_i, letter_x, letter_y, hit1, blank1, valid1.
- Stage 2 (registered): text_on = letter_o && hit1 && !blank1 && !in_load && !blink_off; text_valid = valid1.
- Latency is 2 cycles from pix_x/pix_y to text_on. The font path is combinational within stage 2.
- Reset values:
  - all outputs 0, except wr_ready = 1;
  - FSM in SHOW, wr_ptr = 0, msg_len = 0, frame counter = 0, buffer contents = 31 (blank).
- Reset asserted mid-LOAD discards the partial message; msg_len returns to 0.
- A write accepted in the same cycle as a display lookup of the same slot: the lookup returns the old character. This is only visible in LOAD, where text_on is already forced to 0.
- frame_start and a write in the same cycle are independent; both take effect.
- wr_last on slot MSG_LEN-1 is a single termination event, not a double one.

## Structure
- Shared package text_pkg holds:
  - glyph constants GLYPH_W = 16, GLYPH_H = 16;
  - CHAR_BLANK = 5'd31;
  - the enum wr_state_t {SHOW, LOAD}.
- One sub-module, text_msg_buf: the MSG_LEN × 5 register file with write-port FSM, wr_ptr and msg_len. It has one asynchronous read port.

## Test plan
- Load "HI" (codes 7, 8; wr_last on the 8), SCALE_LOG2 = 1, at pixel (192, 224). Required: letter_i = 7, letter_x = 0, letter_y = 0 two cycles later. At (224, 224): letter_i = 8.
- Drive a font model returning 1 for all pixels. Required: text_on = 1 exactly for x 192..255 and y 224..255 with msg_len = 2. text_on = 0 at x = 191, x = 256 and y = 256.
- Write 16 characters without wr_last. Required: the FSM returns to SHOW after the 16th write, msg_len = 16, and wr_ready = 0 for exactly one cycle.
- Assert sys_rst mid-LOAD after 3 writes. Required: msg_len = 0 and text_on stays 0 for the whole frame.
- Set blink_en = 1 and pulse frame_start 32 times. Required: text_on is suppressed during frames 32..63 and restored at frame 64 (wrap to 0).
- Load code 31 at slot 0 with the font model returning 1. Required: text_on = 0 across slot 0's columns and letter_i = 0.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants and types for the text overlay: glyph geometry,
// the blank character code and the message-buffer write states.
package text_pkg;

    localparam int         GLYPH_W     = 16;
    localparam int         GLYPH_H     = 16;
    localparam logic [4:0] CHAR_BLANK  = 5'd31;
    localparam logic [4:0] FIRST_BLANK = 5'd26;

    typedef enum logic {
        SHOW,
        LOAD
    } wr_state_t;

    function automatic logic is_blank(input logic [4:0] code);
        return code >= FIRST_BLANK;
    endfunction

endpackage

// File: rtl/text_msg_buf.sv
// Message register file with its valid/ready write port. A message is
// collected in LOAD and only becomes visible once it is terminated.
module text_msg_buf
    import text_pkg::*;
#(
    parameter int MSG_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en_i,
    input  logic [4:0] wr_char_i,
    input  logic       wr_last_i,
    output logic       wr_ready_o,
    input  logic [4:0] rd_slot_i,
    output logic [4:0] rd_char_o,
    output logic [5:0] msg_len_o,
    output logic       in_load_o
);

    localparam int PTR_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    wr_state_t  state_q, state_d;
    logic [4:0] wr_ptr_q, wr_ptr_d;
    logic [5:0] msg_len_q, msg_len_d;
    logic       gap_q, gap_d;
    logic [4:0] mem_q [MSG_LEN];
    logic       accept;
    logic       done;

    assign wr_ready_o = !gap_q;
    assign accept     = wr_en_i && wr_ready_o;
    assign done       = accept && (wr_last_i || wr_ptr_q == 5'(MSG_LEN - 1));
    assign in_load_o  = (state_q == LOAD);
    assign msg_len_o  = msg_len_q;

    // Slots beyond the buffer read as blank so stray indices never light pixels.
    assign rd_char_o = ({1'b0, rd_slot_i} < 6'(MSG_LEN)) ? mem_q[rd_slot_i[PTR_W-1:0]]
                                                         : CHAR_BLANK;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        msg_len_d = msg_len_q;
        gap_d     = 1'b0;
        if (done) begin
            state_d   = SHOW;
            wr_ptr_d  = '0;
            msg_len_d = 6'(wr_ptr_q) + 6'd1;
            gap_d     = 1'b1;
        end else if (accept) begin
            state_d  = LOAD;
            wr_ptr_d = wr_ptr_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SHOW;
            wr_ptr_q  <= '0;
            msg_len_q <= '0;
            gap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            msg_len_q <= msg_len_d;
            gap_q     <= gap_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) mem_q[i] <= CHAR_BLANK;
        end else if (accept) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_char_i;
        end
    end

endmodule

// File: rtl/text_renderer.sv
// Two-stage text overlay: stage 1 maps the pixel to a glyph lookup,
// stage 2 registers the returned font bit into text_on.
module text_renderer
    import text_pkg::*;
#(
    parameter int         MSG_LEN    = 16,
    parameter logic [9:0] ORIGIN_X   = 10'd192,
    parameter logic [9:0] ORIGIN_Y   = 10'd224,
    parameter int         SCALE_LOG2 = 1
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_valid,
    input  logic       frame_start,
    input  logic       wr_en,
    input  logic [4:0] wr_char,
    input  logic       wr_last,
    output logic       wr_ready,
    input  logic       blink_en,
    output logic [4:0] letter_i,
    output logic [3:0] letter_x,
    output logic [3:0] letter_y,
    input  logic       letter_o,
    output logic       text_valid,
    output logic       text_on
);

    logic [9:0]  dx, dy;
    logic [11:0] box_w, box_h;
    logic [4:0]  slot, rd_char;
    logic [5:0]  msg_len;
    logic        in_load;
    logic        hit_d, blank_d, text_on_d;
    logic [4:0]  letter_i_d;

    logic [4:0]  letter_i_q;
    logic [3:0]  letter_x_q, letter_y_q;
    logic        hit1_q, blank1_q, valid1_q;
    logic        text_on_q, text_valid_q;
    logic [5:0]  frame_cnt_q;

    text_msg_buf #(.MSG_LEN(MSG_LEN)) u_buf (
        .clk        (vga_clk),
        .rst        (sys_rst),
        .wr_en_i    (wr_en),
        .wr_char_i  (wr_char),
        .wr_last_i  (wr_last),
        .wr_ready_o (wr_ready),
        .rd_slot_i  (slot),
        .rd_char_o  (rd_char),
        .msg_len_o  (msg_len),
        .in_load_o  (in_load)
    );

    assign dx    = pix_x - ORIGIN_X;
    assign dy    = pix_y - ORIGIN_Y;
    assign box_w = 12'(msg_len) << (4 + SCALE_LOG2);
    assign box_h = 12'(GLYPH_H) << SCALE_LOG2;
    assign slot  = 5'(dx >> (4 + SCALE_LOG2));

    assign hit_d = pix_valid && (pix_x >= ORIGIN_X) && (pix_y >= ORIGIN_Y)
                && ({2'b00, dx} < box_w) && ({2'b00, dy} < box_h);
    assign blank_d    = is_blank(rd_char);
    assign letter_i_d = (hit_d && !blank_d) ? rd_char : 5'd0;

    // The upper counter bit selects the dark half of the 64-frame blink cycle.
    assign text_on_d = letter_o && hit1_q && !blank1_q && !in_load
                    && !(blink_en && frame_cnt_q[5]);

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            letter_i_q <= '0;
            letter_x_q <= '0;
            letter_y_q <= '0;
            hit1_q     <= 1'b0;
            blank1_q   <= 1'b0;
            valid1_q   <= 1'b0;
        end else begin
            letter_i_q <= letter_i_d;
            letter_x_q <= 4'(dx >> SCALE_LOG2);
            letter_y_q <= 4'(dy >> SCALE_LOG2);
            hit1_q     <= hit_d;
            blank1_q   <= blank_d;
            valid1_q   <= pix_valid;
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            text_on_q    <= 1'b0;
            text_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            text_on_q    <= text_on_d;
            text_valid_q <= valid1_q;
            if (frame_start) frame_cnt_q <= frame_cnt_q + 6'd1;
        end
    end

    assign letter_i   = letter_i_q;
    assign letter_x   = letter_x_q;
    assign letter_y   = letter_y_q;
    assign text_on    = text_on_q;
    assign text_valid = text_valid_q;

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer: expected text_on values are queued as
// pixels are presented and checked when text_valid emerges from the pipeline.
module tb_text_renderer;

    logic       vga_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       pix_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_char = '0;
    logic       wr_last = 1'b0;
    logic       wr_ready;
    logic       blink_en = 1'b0;
    logic [4:0] letter_i;
    logic [3:0] letter_x;
    logic [3:0] letter_y;
    logic       letter_o;
    logic       text_valid;
    logic       text_on;

    int         assertCount = 0;
    int         failCount   = 0;
    bit         expQ[$];

    int         modelLen = 0;
    int         modelPtr = 0;
    bit         modelLoad = 0;
    logic [4:0] modelChars[16];
    bit         fontAll = 1;
    int         frameCnt = 0;
    bit         blinkOn = 0;

    text_renderer dut (
        .vga_clk     (vga_clk),
        .sys_rst     (sys_rst),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .wr_en       (wr_en),
        .wr_char     (wr_char),
        .wr_last     (wr_last),
        .wr_ready    (wr_ready),
        .blink_en    (blink_en),
        .letter_i    (letter_i),
        .letter_x    (letter_x),
        .letter_y    (letter_y),
        .letter_o    (letter_o),
        .text_valid  (text_valid),
        .text_on     (text_on)
    );

    always #5 vga_clk = ~vga_clk;

    assign letter_o = fontAll ? 1'b1 : (letter_x[0] ^ letter_y[1]);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference for SCALE_LOG2 = 1 at origin (192,224): 32x32-pixel cells.
    function automatic bit expOn(input logic [9:0] x, input logic [9:0] y);
        int dx, dy, slot, lx, ly;
        if (modelLoad) return 1'b0;
        if (blinkOn && frameCnt >= 32) return 1'b0;
        if (int'(x) < 192 || int'(y) < 224) return 1'b0;
        dx = int'(x) - 192;
        dy = int'(y) - 224;
        if (dy >= 32 || dx >= modelLen * 32) return 1'b0;
        slot = dx / 32;
        if (modelChars[slot] >= 5'd26) return 1'b0;
        lx = (dx / 2) % 16;
        ly = (dy / 2) % 16;
        if (fontAll) return 1'b1;
        return bit'((lx % 2) ^ ((ly / 2) % 2));
    endfunction

    always @(posedge vga_clk) begin
        if (pix_valid === 1'b1) expQ.push_back(expOn(pix_x, pix_y));
        #1;
        if (text_valid === 1'b1) begin
            if (expQ.size() == 0) checkOutput("unexpected_text_valid", 1, 0);
            else                  checkOutput("text_on", text_on, expQ.pop_front());
        end else if (!sys_rst) begin
            checkOutput("text_on_idle", text_on, 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge vga_clk);
            pix_valid   = 1'b0;
            wr_en       = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    task automatic doReset();
        @(negedge vga_clk);
        sys_rst = 1'b1;
        modelLen = 0; modelPtr = 0; modelLoad = 0; frameCnt = 0;
        for (int i = 0; i < 16; i++) modelChars[i] = 5'd31;
        @(negedge vga_clk);
        sys_rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [4:0] c, input bit last);
        @(negedge vga_clk);
        pix_valid = 1'b0;
        checkOutput("wr_ready_before_write", wr_ready, 1);
        wr_en = 1'b1; wr_char = c; wr_last = last;
        modelChars[modelPtr] = c;
        modelPtr++;
        if (last || modelPtr == 16) begin
            modelLen = modelPtr; modelPtr = 0; modelLoad = 0;
        end else begin
            modelLoad = 1;
        end
    endtask

    task automatic finishWrite();
        @(negedge vga_clk);
        wr_en = 1'b0; wr_last = 1'b0;
        checkOutput("wr_ready_gap", wr_ready, 0);
        @(negedge vga_clk);
        checkOutput("wr_ready_after_gap", wr_ready, 1);
        idle(2);
    endtask

    task automatic scanRow(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            @(negedge vga_clk);
            pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
        end
        idle(3);
    endtask

    task automatic scanCol(input int x, input int y0, input int y1);
        for (int y = y0; y <= y1; y++) begin
            @(negedge vga_clk);
            pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
        end
        idle(3);
    endtask

    task automatic holdCheck(input int x, input int y, input int expI,
                             input bit chkXY, input int expX, input int expY);
        @(negedge vga_clk);
        pix_valid = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
        @(negedge vga_clk);
        @(negedge vga_clk);
        checkOutput("letter_i", letter_i, expI);
        if (chkXY) begin
            checkOutput("letter_x", letter_x, expX);
            checkOutput("letter_y", letter_y, expY);
        end
        idle(3);
    endtask

    task automatic frameTicks(input int n);
        repeat (n) begin
            @(negedge vga_clk);
            frame_start = 1'b1;
            frameCnt = (frameCnt + 1) % 64;
            @(negedge vga_clk);
            frame_start = 1'b0;
        end
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) modelChars[i] = 5'd31;
        repeat (2) @(negedge vga_clk);
        sys_rst = 1'b0;
        checkOutput("reset_wr_ready", wr_ready, 1);
        checkOutput("reset_text_on", text_on, 0);
        checkOutput("reset_text_valid", text_valid, 0);
        checkOutput("reset_letter_i", letter_i, 0);
        checkOutput("reset_letter_x", letter_x, 0);
        checkOutput("reset_letter_y", letter_y, 0);
        scanRow(230, 188, 200);

        // "HI" with an all-ones font
        applyStimulus(5'd7, 0);
        applyStimulus(5'd8, 1);
        finishWrite();
        holdCheck(192, 224, 7, 1, 0, 0);
        holdCheck(224, 224, 8, 1, 0, 0);
        holdCheck(223, 255, 7, 1, 15, 15);
        holdCheck(191, 224, 0, 0, 0, 0);
        holdCheck(256, 230, 0, 0, 0, 0);
        scanRow(224, 188, 260);
        scanRow(255, 188, 260);
        scanRow(256, 188, 260);
        scanCol(200, 220, 260);
        scanCol(255, 220, 260);
        fontAll = 0;
        scanRow(226, 188, 260);
        scanRow(237, 188, 260);
        fontAll = 1;

        // a message being rewritten stays dark until terminated
        applyStimulus(5'd0, 0);
        idle(3);
        scanRow(230, 188, 260);
        applyStimulus(5'd1, 1);
        finishWrite();
        scanRow(230, 250, 260);

        // 16 characters without wr_last terminate on the last slot
        for (int i = 0; i < 16; i++) applyStimulus(5'(i), 0);
        finishWrite();
        scanRow(230, 188, 194);
        scanRow(230, 698, 710);

        // reset mid-load discards everything
        applyStimulus(5'd3, 0);
        applyStimulus(5'd4, 0);
        applyStimulus(5'd5, 0);
        idle(3);
        doReset();
        checkOutput("rst_mid_load_wr_ready", wr_ready, 1);
        scanRow(224, 188, 300);
        scanRow(240, 188, 300);
        holdCheck(200, 230, 0, 0, 0, 0);

        applyStimulus(5'd7, 0);
        applyStimulus(5'd8, 1);
        finishWrite();

        // blink over one full 64-frame cycle
        blink_en = 1'b1; blinkOn = 1;
        frameTicks(31);
        scanRow(230, 190, 200);
        frameTicks(1);
        scanRow(230, 190, 200);
        blink_en = 1'b0; blinkOn = 0;
        idle(2);
        scanRow(230, 190, 200);
        blink_en = 1'b1; blinkOn = 1;
        idle(2);
        frameTicks(31);
        scanRow(230, 190, 200);
        frameTicks(1);
        scanRow(230, 190, 200);
        blink_en = 1'b0; blinkOn = 0;
        idle(2);

        // blank code in slot 0
        applyStimulus(5'd31, 0);
        applyStimulus(5'd2, 1);
        finishWrite();
        holdCheck(200, 230, 0, 0, 0, 0);
        holdCheck(230, 230, 2, 0, 0, 0);
        scanRow(230, 188, 260);

        idle(4);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
